// File: rtl/cpu_isa_pkg.sv
// rtl/cpu_isa_pkg.sv - opcode constants, decode line indices and sequencer state encoding
package cpu_isa_pkg;

    // Opcode field values (ir[7:4])
    localparam logic [3:0] OP_MOV   = 4'b1100;
    localparam logic [3:0] OP_ADD   = 4'b1001;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_AND   = 4'b1011;
    localparam logic [3:0] OP_NOT   = 4'b0101;
    localparam logic [3:0] OP_SHIFT = 4'b1010;
    localparam logic [3:0] OP_JUMP  = 4'b0011;
    localparam logic [3:0] OP_IN    = 4'b0010;
    localparam logic [3:0] OP_OUT   = 4'b0100;
    localparam logic [3:0] OP_HALT  = 4'b1000;

    // Bit positions of the one-hot decode lines inside the decoder output vector
    localparam int NUM_LINES = 16;
    localparam int LN_MOVA = 0;
    localparam int LN_MOVB = 1;
    localparam int LN_MOVC = 2;
    localparam int LN_ADD  = 3;
    localparam int LN_SUB  = 4;
    localparam int LN_AND1 = 5;
    localparam int LN_NOT1 = 6;
    localparam int LN_RSR  = 7;
    localparam int LN_RSL  = 8;
    localparam int LN_JMP  = 9;
    localparam int LN_JZ   = 10;
    localparam int LN_JC   = 11;
    localparam int LN_IN1  = 12;
    localparam int LN_OUT1 = 13;
    localparam int LN_NOP  = 14;
    localparam int LN_HALT = 15;

    // Sequencer states; every state except FETCH is an execute-phase state
    typedef enum logic [1:0] {
        ST_FETCH = 2'b00,
        ST_EXEC  = 2'b01,
        ST_HALT  = 2'b10,
        ST_WAIT  = 2'b11
    } state_t;

    // Phase bit: 0 while fetching, 1 in any execute-phase state
    function automatic logic phase_of(input state_t s);
        return (s != ST_FETCH);
    endfunction

endpackage

// File: rtl/instr_decoder.sv
// rtl/instr_decoder.sv - combinational one-hot instruction decoder
module instr_decoder
    import cpu_isa_pkg::*;
(
    input  logic [7:0]           i_ir,
    output logic [NUM_LINES-1:0] o_lines
);

    logic [3:0] w_op;
    logic [1:0] w_rd;
    logic [1:0] w_rs;

    assign w_op = i_ir[7:4];
    assign w_rd = i_ir[3:2];
    assign w_rs = i_ir[1:0];

    // Map opcode and register fields onto exactly one line; unknown opcodes become nop
    always_comb begin
        o_lines = '0;
        case (w_op)
            OP_MOV: begin
                if (w_rd == 2'b11 && w_rs == 2'b11)
                    o_lines[LN_NOP] = 1'b1;
                else if (w_rd == 2'b11)
                    o_lines[LN_MOVB] = 1'b1;
                else if (w_rs == 2'b11)
                    o_lines[LN_MOVC] = 1'b1;
                else
                    o_lines[LN_MOVA] = 1'b1;
            end
            OP_ADD:  o_lines[LN_ADD]  = 1'b1;
            OP_SUB:  o_lines[LN_SUB]  = 1'b1;
            OP_AND:  o_lines[LN_AND1] = 1'b1;
            OP_NOT:  o_lines[LN_NOT1] = 1'b1;
            OP_SHIFT: begin
                if (w_rs == 2'b00)
                    o_lines[LN_RSR] = 1'b1;
                else if (w_rs == 2'b11)
                    o_lines[LN_RSL] = 1'b1;
                else
                    o_lines[LN_NOP] = 1'b1;
            end
            OP_JUMP: begin
                case (w_rs)
                    2'b00:   o_lines[LN_JMP] = 1'b1;
                    2'b01:   o_lines[LN_JZ]  = 1'b1;
                    2'b10:   o_lines[LN_JC]  = 1'b1;
                    default: o_lines[LN_NOP] = 1'b1;
                endcase
            end
            OP_IN:   o_lines[LN_IN1]  = 1'b1;
            OP_OUT:  o_lines[LN_OUT1] = 1'b1;
            OP_HALT: o_lines[LN_HALT] = 1'b1;
            default: o_lines[LN_NOP]  = 1'b1;
        endcase
    end

endmodule

// File: rtl/instruction_sequencer.sv
// rtl/instruction_sequencer.sv - fetch/execute sequencer with instruction register and gated decode; IO_HANDSHAKE_EN adds an IN/OUT wait state
module instruction_sequencer
    import cpu_isa_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] bus_in,
    input  logic       ir_ld,
    input  logic       io_ack,
    output logic [7:0] ir,
    output logic       sm,
    output logic       mova,
    output logic       movb,
    output logic       movc,
    output logic       add,
    output logic       sub,
    output logic       and1,
    output logic       not1,
    output logic       rsr,
    output logic       rsl,
    output logic       jmp,
    output logic       jz,
    output logic       jc,
    output logic       in1,
    output logic       out1,
    output logic       nop,
    output logic       halt
);

    state_t                r_state;
    state_t                w_state_next;
    logic [7:0]            r_ir;
    logic [NUM_LINES-1:0]  w_dec_lines;
    logic [NUM_LINES-1:0]  w_lines;
    logic                  w_phase;

`ifndef IO_HANDSHAKE_EN
    // Acknowledge is only meaningful with the handshake build
    logic w_unused_io_ack;
    assign w_unused_io_ack = io_ack;
`endif

    instr_decoder u_decoder (
        .i_ir    (r_ir),
        .o_lines (w_dec_lines)
    );

    // State register; reset aborts any phase immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= ST_FETCH;
        else
            r_state <= w_state_next;
    end

    // Instruction register loads only during the fetch phase
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_ir <= 8'h00;
        else if (r_state == ST_FETCH && ir_ld)
            r_ir <= bus_in;
    end

    // Next-state logic: fetch always advances; halt is sticky until reset
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_FETCH: w_state_next = ST_EXEC;
            ST_EXEC: begin
                if (w_dec_lines[LN_HALT])
                    w_state_next = ST_HALT;
`ifdef IO_HANDSHAKE_EN
                else if ((w_dec_lines[LN_IN1] || w_dec_lines[LN_OUT1]) && !io_ack)
                    w_state_next = ST_WAIT;
`endif
                else
                    w_state_next = ST_FETCH;
            end
            ST_HALT: w_state_next = ST_HALT;
            ST_WAIT: begin
`ifdef IO_HANDSHAKE_EN
                if (io_ack)
                    w_state_next = ST_FETCH;
`else
                w_state_next = ST_FETCH;
`endif
            end
            default: w_state_next = ST_FETCH;
        endcase
    end

    // Decode lines are quiet in fetch, live in every execute-phase state
    always_comb begin
        w_phase = phase_of(r_state);
        w_lines = w_phase ? w_dec_lines : '0;
    end

    assign ir   = r_ir;
    assign sm   = w_phase;
    assign mova = w_lines[LN_MOVA];
    assign movb = w_lines[LN_MOVB];
    assign movc = w_lines[LN_MOVC];
    assign add  = w_lines[LN_ADD];
    assign sub  = w_lines[LN_SUB];
    assign and1 = w_lines[LN_AND1];
    assign not1 = w_lines[LN_NOT1];
    assign rsr  = w_lines[LN_RSR];
    assign rsl  = w_lines[LN_RSL];
    assign jmp  = w_lines[LN_JMP];
    assign jz   = w_lines[LN_JZ];
    assign jc   = w_lines[LN_JC];
    assign in1  = w_lines[LN_IN1];
    assign out1 = w_lines[LN_OUT1];
    assign nop  = w_lines[LN_NOP];
    assign halt = w_lines[LN_HALT];

endmodule

// File: tb/tb_instruction_sequencer.sv
// tb/tb_instruction_sequencer.sv - scoreboard bench for instruction_sequencer
module tb_instruction_sequencer;

    // Expected line vectors, ordered {mova ... halt} MSB first
    localparam logic [15:0] L_NONE = 16'h0000;
    localparam logic [15:0] L_MOVA = 16'h8000;
    localparam logic [15:0] L_MOVB = 16'h4000;
    localparam logic [15:0] L_MOVC = 16'h2000;
    localparam logic [15:0] L_ADD  = 16'h1000;
    localparam logic [15:0] L_SUB  = 16'h0800;
    localparam logic [15:0] L_AND1 = 16'h0400;
    localparam logic [15:0] L_NOT1 = 16'h0200;
    localparam logic [15:0] L_RSR  = 16'h0100;
    localparam logic [15:0] L_RSL  = 16'h0080;
    localparam logic [15:0] L_JMP  = 16'h0040;
    localparam logic [15:0] L_JZ   = 16'h0020;
    localparam logic [15:0] L_JC   = 16'h0010;
    localparam logic [15:0] L_IN1  = 16'h0008;
    localparam logic [15:0] L_OUT1 = 16'h0004;
    localparam logic [15:0] L_NOP  = 16'h0002;
    localparam logic [15:0] L_HALT = 16'h0001;

    logic       clk;
    logic       rst_n;
    logic [7:0] bus_in;
    logic       ir_ld;
    logic       io_ack;
    logic [7:0] ir;
    logic       sm;
    logic       mova, movb, movc, add, sub, and1, not1, rsr, rsl;
    logic       jmp, jz, jc, in1, out1, nop, halt;

    typedef struct {
        logic [7:0]  e_ir;
        logic        e_sm;
        logic [15:0] e_lines;
        string       name;
    } exp_t;

    exp_t q[$];
    int   n_tests;
    int   n_fail;

    instruction_sequencer dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_in (bus_in),
        .ir_ld  (ir_ld),
        .io_ack (io_ack),
        .ir     (ir),
        .sm     (sm),
        .mova   (mova),
        .movb   (movb),
        .movc   (movc),
        .add    (add),
        .sub    (sub),
        .and1   (and1),
        .not1   (not1),
        .rsr    (rsr),
        .rsl    (rsl),
        .jmp    (jmp),
        .jz     (jz),
        .jc     (jc),
        .in1    (in1),
        .out1   (out1),
        .nop    (nop),
        .halt   (halt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] act_lines;
    assign act_lines = {mova, movb, movc, add, sub, and1, not1, rsr, rsl,
                        jmp, jz, jc, in1, out1, nop, halt};

    task automatic push(input logic [7:0] eir, input logic esm,
                        input logic [15:0] el, input string nm);
        exp_t e;
        e.e_ir = eir;
        e.e_sm = esm;
        e.e_lines = el;
        e.name = nm;
        q.push_back(e);
    endtask

    // One clock: drive inputs, take the edge, record what must follow it
    task automatic cyc(input logic [7:0] b, input logic ld, input logic io,
                       input logic [7:0] eir, input logic esm,
                       input logic [15:0] el, input string nm);
        bus_in = b;
        ir_ld  = ld;
        io_ack = io;
        @(posedge clk);
        #1;
        push(eir, esm, el, nm);
    endtask

    // Fetch then execute; the execute cycle presents a different byte with ir_ld high
    task automatic pair(input logic [7:0] b, input logic [15:0] el, input string nm);
        logic [7:0] other;
        other = ~b;
        cyc(b, 1'b1, 1'b0, b, 1'b1, el, {nm, "_exec"});
        cyc(other, 1'b1, 1'b1, b, 1'b0, L_NONE, {nm, "_fetch"});
    endtask

    // Monitor: sample away from the active edge and compare against the scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (q.size() > 0) begin
                e = q.pop_front();
                n_tests++;
                if (ir !== e.e_ir || sm !== e.e_sm || act_lines !== e.e_lines) begin
                    n_fail++;
                    $display("FAIL %s: got ir=%02h sm=%b lines=%04h, expected ir=%02h sm=%b lines=%04h",
                             e.name, ir, sm, act_lines, e.e_ir, e.e_sm, e.e_lines);
                end
            end
        end
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        bus_in  = 8'hFF;
        ir_ld   = 1'b1;
        io_ack  = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        push(8'h00, 1'b0, L_NONE, "reset_state");
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        ir_ld = 1'b0;

        pair(8'h95, L_ADD,  "add_95");
        pair(8'hC3, L_MOVC, "movc_c3");
        pair(8'hCC, L_MOVB, "movb_cc");
        pair(8'hCF, L_NOP,  "nop_cf");
        pair(8'hC4, L_MOVA, "mova_c4");
        pair(8'h31, L_JZ,   "jz_31");
        pair(8'h32, L_JC,   "jc_32");
        pair(8'h30, L_JMP,  "jmp_30");
        pair(8'h33, L_NOP,  "nop_33");
        pair(8'hA1, L_NOP,  "nop_a1");
        pair(8'h70, L_NOP,  "nop_70");
        pair(8'h60, L_SUB,  "sub_60");
        pair(8'hB0, L_AND1, "and_b0");
        pair(8'h50, L_NOT1, "not_50");
        pair(8'hA0, L_RSR,  "rsr_a0");
        pair(8'hA3, L_RSL,  "rsl_a3");
        pair(8'h40, L_OUT1, "out_ack_40");

        // IN instruction with acknowledge held low in execute
        cyc(8'h20, 1'b1, 1'b0, 8'h20, 1'b1, L_IN1, "in_exec");
`ifdef IO_HANDSHAKE_EN
        for (int i = 0; i < 3; i++)
            cyc(8'h55, 1'b1, 1'b0, 8'h20, 1'b1, L_IN1, "in_wait");
        cyc(8'h55, 1'b1, 1'b1, 8'h20, 1'b0, L_NONE, "in_ack_fetch");
`else
        cyc(8'h55, 1'b1, 1'b0, 8'h20, 1'b0, L_NONE, "in_noack_fetch");
`endif

        // Halt is sticky and ignores ir_ld
        cyc(8'h80, 1'b1, 1'b0, 8'h80, 1'b1, L_HALT, "halt_exec");
        for (int i = 0; i < 10; i++)
            cyc(8'h95, logic'(i % 2), 1'b1, 8'h80, 1'b1, L_HALT, "halt_hold");
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        push(8'h00, 1'b0, L_NONE, "halt_async_rst");
        @(negedge clk);
        #2;
        rst_n  = 1'b1;
        pair(8'hC3, L_MOVC, "after_halt_rst");

        // Reset lands in the middle of an execute cycle
        bus_in = 8'h20;
        ir_ld  = 1'b1;
        io_ack = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        push(8'h00, 1'b0, L_NONE, "exec_async_rst");
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        cyc(8'h95, 1'b1, 1'b0, 8'h95, 1'b1, L_ADD, "post_rst_exec");
        cyc(8'h00, 1'b0, 1'b0, 8'h95, 1'b0, L_NONE, "post_rst_fetch");

        #20;
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
